// File: rtl/swap_ctrl_if.sv
// Bus bundle for swap_ctrl: load port, swap handshake, read port and optional swap counter.
// The swap_cnt signal only exists when SWAP_COUNT_EN is defined.
interface swap_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             ld_en;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic             sw_req;
  logic [AW-1:0]    sw_a;
  logic [AW-1:0]    sw_b;
  logic             sw_ack;
  logic             busy;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
`ifdef SWAP_COUNT_EN
  logic [15:0]      swap_cnt;

  modport master (
    output ld_en, ld_addr, ld_data, sw_req, sw_a, sw_b, rd_addr,
    input  sw_ack, busy, rd_data, swap_cnt
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, sw_req, sw_a, sw_b, rd_addr,
    output sw_ack, busy, rd_data, swap_cnt
  );
`else
  modport master (
    output ld_en, ld_addr, ld_data, sw_req, sw_a, sw_b, rd_addr,
    input  sw_ack, busy, rd_data
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, sw_req, sw_a, sw_b, rd_addr,
    output sw_ack, busy, rd_data
  );
`endif
endinterface

// File: rtl/swap_ctrl.sv
// Register-bank swap sequencer: captures two entries, writes them back crossed, then
// completes a four-phase req/ack handshake. Optional completed-swap counter under SWAP_COUNT_EN.
module swap_ctrl #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  swap_ctrl_if.slave   bus
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XCHG = 2'b01,
    ACK  = 2'b10
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] regs_r [DEPTH];
  logic [AW-1:0]    a_r;
  logic [AW-1:0]    b_r;
  logic [WIDTH-1:0] ta_r;
  logic [WIDTH-1:0] tb_r;
  logic             ack_r;
`ifdef SWAP_COUNT_EN
  logic [15:0]      cnt_r;
`endif

  // Sequencer, register bank and handshake; the bank is written only in IDLE (load) or XCHG (swap)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= '0;
      end
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      ta_r    <= '0;
      tb_r    <= '0;
      ack_r   <= 1'b0;
`ifdef SWAP_COUNT_EN
      cnt_r   <= 16'h0000;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.ld_en) begin
            regs_r[bus.ld_addr] <= bus.ld_data;
          end else if (bus.sw_req) begin
            a_r     <= bus.sw_a;
            b_r     <= bus.sw_b;
            ta_r    <= regs_r[bus.sw_a];
            tb_r    <= regs_r[bus.sw_b];
            state_r <= XCHG;
          end else begin
            state_r <= IDLE;
          end
        end
        XCHG: begin
          // With a == b both writes hit one entry; ta == tb so the contents are unchanged
          regs_r[a_r] <= tb_r;
          regs_r[b_r] <= ta_r;
          ack_r       <= 1'b1;
`ifdef SWAP_COUNT_EN
          cnt_r       <= cnt_r + 16'd1;
`endif
          state_r     <= ACK;
        end
        ACK: begin
          if (!bus.sw_req) begin
            ack_r   <= 1'b0;
            state_r <= IDLE;
          end else begin
            ack_r   <= 1'b1;
          end
        end
        default: begin
          ack_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.sw_ack  = ack_r;
  assign bus.busy    = (state_r != IDLE);
  assign bus.rd_data = regs_r[bus.rd_addr];
`ifdef SWAP_COUNT_EN
  assign bus.swap_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_swap_ctrl.sv
// Self-checking bench for swap_ctrl: directed table, hand-written corner sequences and
// randomized transactions checked against a transaction-level bank model.
module tb_swap_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [7:0]  model [4];
  logic [15:0] cnt_m;

  swap_ctrl_if #(.WIDTH(8), .AW(2)) bus ();

  swap_ctrl #(.WIDTH(8), .AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         kind;   // 0 load, 1 swap, 2 read check
    logic [1:0] addr;
    logic [1:0] addr_b;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rd(input logic [1:0] a, input logic [7:0] e, input string name);
    bus.rd_addr = a;
    #1;
    check(name, {24'd0, bus.rd_data}, {24'd0, e});
  endtask

  task automatic chk_bank(input string name);
    for (int i = 0; i < 4; i++) begin
      chk_rd(2'(i), model[i], name);
    end
  endtask

  task automatic do_load(input logic [1:0] a, input logic [7:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    tick();
    bus.ld_en   = 1'b0;
    model[a]    = d;
  endtask

  // One full transaction; drop releases sw_req during XCHG, busy_ld attempts a load while busy
  task automatic do_swap(input logic [1:0] a, input logic [1:0] b, input int hold,
                         input bit drop, input bit busy_ld);
    logic [7:0] pa;
    logic [7:0] pb;
    bus.sw_req = 1'b1;
    bus.sw_a   = a;
    bus.sw_b   = b;
    tick();
    check("busy_xchg", {31'd0, bus.busy}, 32'd1);
    check("ack_xchg", {31'd0, bus.sw_ack}, 32'd0);
    pa = model[a];
    pb = model[b];
    bus.sw_a = ~a;
    bus.sw_b = ~b;
    chk_rd(a, pa, "rd_pre_swap");
    if (drop) bus.sw_req = 1'b0;
    if (busy_ld) begin
      bus.ld_en   = 1'b1;
      bus.ld_addr = 2'($urandom_range(0, 3));
      bus.ld_data = 8'($urandom);
    end
    tick();
    bus.ld_en = 1'b0;
    model[a] = pb;
    model[b] = pa;
    cnt_m    = cnt_m + 16'd1;
    check("ack_n1", {31'd0, bus.sw_ack}, 32'd1);
    check("busy_ack", {31'd0, bus.busy}, 32'd1);
    chk_rd(a, model[a], "rd_post_a");
    chk_rd(b, model[b], "rd_post_b");
`ifdef SWAP_COUNT_EN
    check("swap_cnt", {16'd0, bus.swap_cnt}, {16'd0, cnt_m});
`endif
    if (!drop) begin
      for (int h = 0; h < hold; h++) begin
        tick();
        check("ack_hold", {31'd0, bus.sw_ack}, 32'd1);
        check("busy_hold", {31'd0, bus.busy}, 32'd1);
      end
    end
    bus.sw_req = 1'b0;
    tick();
    check("ack_drop", {31'd0, bus.sw_ack}, 32'd0);
    check("busy_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cnt_m  = 16'h0000;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;

    tbl[0] = '{kind: 0, addr: 2'd0, addr_b: 2'd0, data: 8'hA5, exp: 8'h00};
    tbl[1] = '{kind: 0, addr: 2'd3, addr_b: 2'd0, data: 8'h3C, exp: 8'h00};
    tbl[2] = '{kind: 1, addr: 2'd0, addr_b: 2'd3, data: 8'h00, exp: 8'h00};
    tbl[3] = '{kind: 2, addr: 2'd0, addr_b: 2'd0, data: 8'h00, exp: 8'h3C};
    tbl[4] = '{kind: 2, addr: 2'd3, addr_b: 2'd0, data: 8'h00, exp: 8'hA5};
    tbl[5] = '{kind: 0, addr: 2'd1, addr_b: 2'd0, data: 8'h11, exp: 8'h00};
    tbl[6] = '{kind: 1, addr: 2'd1, addr_b: 2'd1, data: 8'h00, exp: 8'h00};
    tbl[7] = '{kind: 2, addr: 2'd1, addr_b: 2'd0, data: 8'h00, exp: 8'h11};
    tbl[8] = '{kind: 2, addr: 2'd2, addr_b: 2'd0, data: 8'h00, exp: 8'h00};
    tbl[9] = '{kind: 2, addr: 2'd0, addr_b: 2'd0, data: 8'h00, exp: 8'h3C};

    rst_n       = 1'b0;
    bus.ld_en   = 1'b0;
    bus.ld_addr = 2'd0;
    bus.ld_data = 8'h00;
    bus.sw_req  = 1'b0;
    bus.sw_a    = 2'd0;
    bus.sw_b    = 2'd0;
    bus.rd_addr = 2'd0;

    // Reset state
    tick();
    tick();
    check("rst_ack", {31'd0, bus.sw_ack}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 4; i++) chk_rd(2'(i), 8'h00, "rst_rd");
`ifdef SWAP_COUNT_EN
    check("rst_cnt", {16'd0, bus.swap_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 10; i++) begin
      case (tbl[i].kind)
        0: do_load(tbl[i].addr, tbl[i].data);
        1: do_swap(tbl[i].addr, tbl[i].addr_b, 1, 1'b0, 1'b0);
        default: chk_rd(tbl[i].addr, tbl[i].exp, "table_rd");
      endcase
    end

    // Load to entry 2 while busy is ignored
    do_load(2'd2, 8'h22);
    bus.sw_req = 1'b1;
    bus.sw_a   = 2'd0;
    bus.sw_b   = 2'd1;
    tick();
    bus.ld_en   = 1'b1;
    bus.ld_addr = 2'd2;
    bus.ld_data = 8'hFF;
    tick();
    tick();
    bus.ld_en  = 1'b0;
    bus.sw_req = 1'b0;
    tick();
    chk_rd(2'd2, 8'h22, "busy_load_ignored");
    chk_rd(2'd0, 8'h11, "busy_swap_a");
    chk_rd(2'd1, 8'h3C, "busy_swap_b");
    model[0] = 8'h11;
    model[1] = 8'h3C;
    cnt_m    = cnt_m + 16'd1;

    // Load and request on the same IDLE edge: load first, swap sees loaded value
    bus.ld_en   = 1'b1;
    bus.ld_addr = 2'd0;
    bus.ld_data = 8'h77;
    bus.sw_req  = 1'b1;
    bus.sw_a    = 2'd0;
    bus.sw_b    = 2'd2;
    tick();
    bus.ld_en = 1'b0;
    check("ld_wins_busy", {31'd0, bus.busy}, 32'd0);
    model[0] = 8'h77;
    do_swap(2'd0, 2'd2, 0, 1'b0, 1'b0);
    chk_rd(2'd2, 8'h77, "ld_then_swap");

    // sw_req dropped in XCHG: ack for exactly one cycle
    do_swap(2'd1, 2'd3, 0, 1'b1, 1'b0);

    // Reset during XCHG: no write, everything cleared
    bus.sw_req = 1'b1;
    bus.sw_a   = 2'd0;
    bus.sw_b   = 2'd3;
    tick();
    rst_n      = 1'b0;
    bus.sw_req = 1'b0;
    tick();
    check("rst_x_ack", {31'd0, bus.sw_ack}, 32'd0);
    check("rst_x_busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    cnt_m = 16'h0000;
    chk_bank("rst_x_bank");
`ifdef SWAP_COUNT_EN
    check("rst_x_cnt", {16'd0, bus.swap_cnt}, 32'd0);
`endif
    tick();

    // Randomized transactions
    for (int it = 0; it < 80; it++) begin
      int op;
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        do_load(2'($urandom_range(0, 3)), 8'($urandom));
      end else begin
        bit drop;
        drop = ($urandom_range(0, 3) == 0);
        do_swap(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), drop, bit'($urandom_range(0, 1)));
      end
      chk_bank("rand_bank");
    end

`ifdef SWAP_COUNT_EN
    // Counter wrap
    force dut.cnt_r = 16'hFFFF;
    #1;
    release dut.cnt_r;
    cnt_m = 16'hFFFF;
    do_swap(2'd0, 2'd1, 0, 1'b0, 1'b0);
    check("cnt_wrap", {16'd0, bus.swap_cnt}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
